// File: rtl/quad_dispatch_pkg.sv
// Shared types and constants for the quad_dispatch batch scheduler.
package quad_dispatch_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BUS_W  = LANES * DATA_W;

  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Operand payload of one FPU job, g = (a + b) * c - d.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ops_t;

  // Extract lane idx from a 128-bit lane-packed bus.
  function automatic logic [DATA_W-1:0] lane_slice(input logic [BUS_W-1:0] bus,
                                                   input int unsigned idx);
    return bus[DATA_W*idx +: DATA_W];
  endfunction

endpackage

// File: rtl/qd_lane_slot.sv
// One core lane: operand/tag storage plus sticky result capture and abort marking.
module qd_lane_slot
  import quad_dispatch_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  ops_t              ops_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              active,
  input  logic              fi,
  input  logic [DATA_W-1:0] g,
  input  logic              abort,
  input  logic              clr,
  output ops_t              ops,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] res,
  output logic              done,
  output logic              err
);

  // A finishing lane wins over a same-edge watchdog abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops  <= '0;
      tag  <= '0;
      res  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else if (clr) begin
      ops  <= '0;
      tag  <= '0;
      res  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (wr) begin
        ops <= ops_in;
        tag <= tag_in;
      end
      if (active && !done) begin
        if (fi) begin
          done <= 1'b1;
          res  <= g;
        end else if (abort) begin
          res <= QNAN;
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quad_dispatch.sv
// Packs up to four FPU jobs into quad_core lanes, launches them together and
// returns results in acceptance order; a watchdog aborts hung batches.
module quad_dispatch
  import quad_dispatch_pkg::*;
#(
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter int unsigned WDOG_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic [DATA_W-1:0] in_d,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              core_en,
  output logic [BUS_W-1:0]  core_a,
  output logic [BUS_W-1:0]  core_b,
  output logic [BUS_W-1:0]  core_c,
  output logic [BUS_W-1:0]  core_d,
  input  logic [LANES-1:0]  core_fi,
  input  logic [BUS_W-1:0]  core_g,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              busy
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned RP_W   = 2;
  localparam int unsigned IDLE_W = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WD_W   = $clog2(WDOG_CYCLES + 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_acc;
  logic [RP_W-1:0]     rp, rp_nxt;
  logic [IDLE_W-1:0]   idle_t, idle_nxt;
  logic [WD_W-1:0]     wd_t, wd_nxt;
  logic                accept, abort, clr, all_done;
  logic [LANES-1:0]    wr, occ, active, done, err;
  ops_t                job;
  ops_t                lane_ops [LANES];
  logic [TAG_W-1:0]    lane_tag [LANES];
  logic [DATA_W-1:0]   lane_res [LANES];

  assign job = '{a: in_a, b: in_b, c: in_c, d: in_d};

  // Next-state, counters and lane strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rp_nxt    = rp;
    idle_nxt  = idle_t;
    wd_nxt    = wd_t;
    abort     = 1'b0;
    clr       = 1'b0;
    wr        = '0;
    accept    = in_valid && in_ready;
    cnt_acc   = cnt + CNT_W'(accept);
    for (int unsigned i = 0; i < LANES; i++) occ[i] = CNT_W'(i) < cnt;
    active    = (state == RUN) ? occ : '0;
    all_done  = &(~occ | done | core_fi);
    if (accept) wr[cnt[RP_W-1:0]] = 1'b1;

    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = cnt_acc;
          idle_nxt  = '0;
          wd_nxt    = '0;
          state_nxt = flush ? RUN : FILL;
        end
      end
      FILL: begin
        cnt_nxt  = cnt_acc;
        idle_nxt = accept ? '0 : idle_t + IDLE_W'(1);
        if ((cnt_acc == CNT_W'(LANES)) || flush ||
            (!accept && (32'(idle_t) + 32'd1 >= FLUSH_CYCLES))) begin
          state_nxt = RUN;
          idle_nxt  = '0;
          wd_nxt    = '0;
        end
      end
      RUN: begin
        wd_nxt = wd_t + WD_W'(1);
        rp_nxt = '0;
        if (all_done) begin
          state_nxt = DRAIN;
        end else if (32'(wd_t) + 32'd1 >= WDOG_CYCLES) begin
          abort     = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          if (32'(rp) + 32'd1 == 32'(cnt)) begin
            clr       = 1'b1;
            cnt_nxt   = '0;
            rp_nxt    = '0;
            state_nxt = IDLE;
          end else begin
            rp_nxt = rp + RP_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered handshake/control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rp        <= '0;
      idle_t    <= '0;
      wd_t      <= '0;
      core_en   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rp        <= rp_nxt;
      idle_t    <= idle_nxt;
      wd_t      <= wd_nxt;
      core_en   <= (state_nxt == RUN);
      out_valid <= (state_nxt == DRAIN);
      busy      <= (state_nxt != IDLE);
      in_ready  <= (state_nxt == IDLE) ||
                   ((state_nxt == FILL) && (cnt_nxt < CNT_W'(LANES)));
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    qd_lane_slot #(.TAG_W(TAG_W)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .wr     (wr[i]),
      .ops_in (job),
      .tag_in (in_tag),
      .active (active[i]),
      .fi     (core_fi[i]),
      .g      (lane_slice(core_g, i)),
      .abort  (abort),
      .clr    (clr),
      .ops    (lane_ops[i]),
      .tag    (lane_tag[i]),
      .res    (lane_res[i]),
      .done   (done[i]),
      .err    (err[i])
    );
    assign core_a[DATA_W*i +: DATA_W] = lane_ops[i].a;
    assign core_b[DATA_W*i +: DATA_W] = lane_ops[i].b;
    assign core_c[DATA_W*i +: DATA_W] = lane_ops[i].c;
    assign core_d[DATA_W*i +: DATA_W] = lane_ops[i].d;
  end

  // Result port shows lane rp; all lane registers are flops.
  assign out_data = lane_res[rp];
  assign out_tag  = lane_tag[rp];
  assign out_err  = err[rp];

endmodule
